mem_port_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single main-memory block port shared by the instruction-side and data-side 4-way caches. It accepts whole-block read (fill) and write (write-back) requests, grants one at a time with round-robin fairness, and drives the memory handshake. It returns fill data or a completion pulse to the owner, and flags a timeout if memory never acknowledges. It sits between the cache controllers' miss/evict paths and the memory model.

---
 rtl/mem_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one main-memory block port between the I-side (requester 0) and
// D-side (requester 1) caches. One whole-block transaction is in flight at a
// time. Owners are chosen round-robin. Fill data or a completion pulse is
// returned to the owner, and a watchdog aborts a transaction when memory
// never acknowledges it.
module mem_port_arbiter #(
    parameter int PA_WIDTH  = 32,
    parameter int BLK_WIDTH = 512,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           rq_valid,
    input  logic [1:0]           rq_we,
    input  logic [PA_WIDTH-1:0]  rq_addr0,
    input  logic [PA_WIDTH-1:0]  rq_addr1,
    input  logic [BLK_WIDTH-1:0] rq_wblk0,
    input  logic [BLK_WIDTH-1:0] rq_wblk1,
    output logic [1:0]           rq_done,
    output logic [1:0]           rq_err,
    output logic [BLK_WIDTH-1:0] rq_rblk,
    output logic [PA_WIDTH-1:0]  mem_addr,
    output logic                 mem_rd_en,
    output logic                 mem_wr_en,
    output logic [BLK_WIDTH-1:0] mem_wr_blk,
    input  logic [BLK_WIDTH-1:0] mem_rd_blk,
    input  logic                 mem_ack
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Watchdog limit; TIMEOUT is at least 1 and fits in 8 bits.
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    logic [1:0]           state_q,      state_d;
    logic                 last_grant_q, last_grant_d;
    logic                 owner_q,      owner_d;
    logic [7:0]           wd_q,         wd_d;
    logic [PA_WIDTH-1:0]  mem_addr_q,   mem_addr_d;
    logic [BLK_WIDTH-1:0] mem_wr_blk_q, mem_wr_blk_d;
    logic                 mem_rd_en_q,  mem_rd_en_d;
    logic                 mem_wr_en_q,  mem_wr_en_d;
    logic [1:0]           rq_done_q,    rq_done_d;
    logic [1:0]           rq_err_q,     rq_err_d;
    logic [BLK_WIDTH-1:0] rq_rblk_q,    rq_rblk_d;

    logic                 grant_s;
    logic [1:0]           owner_onehot_s;

    // Pick the winner among the currently valid requesters.
    always_comb begin
        grant_s = 1'b0;
        if (rq_valid == 2'b11) begin
            // Under contention, the requester that did not win last time goes next.
            grant_s = ~last_grant_q;
        end else begin
            // With a single requester, that requester wins.
            grant_s = rq_valid[1];
        end
        owner_onehot_s = owner_q ? 2'b10 : 2'b01;
    end

    // Compute next-state for the IDLE/BUSY/RESP sequencer and all datapath registers.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        wd_d         = wd_q;
        mem_addr_d   = mem_addr_q;
        mem_wr_blk_d = mem_wr_blk_q;
        mem_rd_en_d  = mem_rd_en_q;
        mem_wr_en_d  = mem_wr_en_q;
        rq_done_d    = 2'b00;
        rq_err_d     = 2'b00;
        rq_rblk_d    = rq_rblk_q;

        case (state_q)
            ST_IDLE: begin
                if (rq_valid != 2'b00) begin
                    owner_d      = grant_s;
                    last_grant_d = grant_s;
                    mem_addr_d   = grant_s ? rq_addr1 : rq_addr0;
                    mem_wr_blk_d = grant_s ? rq_wblk1 : rq_wblk0;
                    mem_rd_en_d  = ~rq_we[grant_s];
                    mem_wr_en_d  = rq_we[grant_s];
                    wd_d         = 8'd0;
                    state_d      = ST_BUSY;
                end else begin
                    mem_rd_en_d = 1'b0;
                    mem_wr_en_d = 1'b0;
                end
            end
            ST_BUSY: begin
                if (mem_ack) begin
                    // Fill data is captured only for reads; write-backs leave it intact.
                    if (mem_rd_en_q) begin
                        rq_rblk_d = mem_rd_blk;
                    end else begin
                        rq_rblk_d = rq_rblk_q;
                    end
                    mem_rd_en_d = 1'b0;
                    mem_wr_en_d = 1'b0;
                    rq_done_d   = owner_onehot_s;
                    state_d     = ST_RESP;
                end else if (wd_q == TIMEOUT_C) begin
                    mem_rd_en_d = 1'b0;
                    mem_wr_en_d = 1'b0;
                    rq_done_d   = owner_onehot_s;
                    rq_err_d    = owner_onehot_s;
                    state_d     = ST_RESP;
                end else begin
                    wd_d = wd_q + 8'd1;
                end
            end
            ST_RESP: begin
                // The done/err pulse is on the outputs this cycle; requests are not sampled.
                state_d = ST_IDLE;
            end
            default: begin
                mem_rd_en_d = 1'b0;
                mem_wr_en_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            wd_q         <= 8'd0;
            mem_addr_q   <= '0;
            mem_wr_blk_q <= '0;
            mem_rd_en_q  <= 1'b0;
            mem_wr_en_q  <= 1'b0;
            rq_done_q    <= 2'b00;
            rq_err_q     <= 2'b00;
            rq_rblk_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            wd_q         <= wd_d;
            mem_addr_q   <= mem_addr_d;
            mem_wr_blk_q <= mem_wr_blk_d;
            mem_rd_en_q  <= mem_rd_en_d;
            mem_wr_en_q  <= mem_wr_en_d;
            rq_done_q    <= rq_done_d;
            rq_err_q     <= rq_err_d;
            rq_rblk_q    <= rq_rblk_d;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_wr_blk = mem_wr_blk_q;
    assign mem_rd_en  = mem_rd_en_q;
    assign mem_wr_en  = mem_wr_en_q;
    assign rq_done    = rq_done_q;
    assign rq_err     = rq_err_q;
    assign rq_rblk    = rq_rblk_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter, built with a short watchdog (TIMEOUT = 4).
module tb_mem_port_arbiter;

    localparam int PA  = 32;
    localparam int BLK = 512;

    logic           clk;
    logic           rst_n;
    logic [1:0]     rq_valid;
    logic [1:0]     rq_we;
    logic [PA-1:0]  rq_addr0;
    logic [PA-1:0]  rq_addr1;
    logic [BLK-1:0] rq_wblk0;
    logic [BLK-1:0] rq_wblk1;
    logic [1:0]     rq_done;
    logic [1:0]     rq_err;
    logic [BLK-1:0] rq_rblk;
    logic [PA-1:0]  mem_addr;
    logic           mem_rd_en;
    logic           mem_wr_en;
    logic [BLK-1:0] mem_wr_blk;
    logic [BLK-1:0] mem_rd_blk;
    logic           mem_ack;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [BLK-1:0] pat_a;
    logic [BLK-1:0] pat_b;
    logic [BLK-1:0] pat_c;
    logic [BLK-1:0] pat_d;
    logic [BLK-1:0] pat_e;

    mem_port_arbiter #(.PA_WIDTH(PA), .BLK_WIDTH(BLK), .TIMEOUT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rq_valid   (rq_valid),
        .rq_we      (rq_we),
        .rq_addr0   (rq_addr0),
        .rq_addr1   (rq_addr1),
        .rq_wblk0   (rq_wblk0),
        .rq_wblk1   (rq_wblk1),
        .rq_done    (rq_done),
        .rq_err     (rq_err),
        .rq_rblk    (rq_rblk),
        .mem_addr   (mem_addr),
        .mem_rd_en  (mem_rd_en),
        .mem_wr_en  (mem_wr_en),
        .mem_wr_blk (mem_wr_blk),
        .mem_rd_blk (mem_rd_blk),
        .mem_ack    (mem_ack)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used to measure spacing between done pulses.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [BLK-1:0] obs, input logic [BLK-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rd_en"}, BLK'(mem_rd_en), BLK'(1'b0));
        check({tag, "_wr_en"}, BLK'(mem_wr_en), BLK'(1'b0));
        check({tag, "_done"},  BLK'(rq_done),   BLK'(2'b00));
        check({tag, "_err"},   BLK'(rq_err),    BLK'(2'b00));
    endtask

    initial begin
        int last_done_cyc;
        int gap;
        logic [1:0] exp_done;
        logic [PA-1:0] exp_addr;

        pat_a = {16{32'hA5A5_0001}};
        pat_b = {16{32'hB0B0_0002}};
        pat_c = {16{32'hC3C3_0003}};
        pat_d = {16{32'hD4D4_0004}};
        pat_e = {16{32'hE7E7_0005}};

        rst_n      = 1'b0;
        rq_valid   = 2'b00;
        rq_we      = 2'b00;
        rq_addr0   = 32'h0;
        rq_addr1   = 32'h0;
        rq_wblk0   = '0;
        rq_wblk1   = '0;
        mem_rd_blk = '0;
        mem_ack    = 1'b0;

        // Reset state
        #1;
        check_idle_outputs("rst");
        check("rst_addr",  BLK'(mem_addr), BLK'(32'h0));
        check("rst_wblk",  mem_wr_blk, '0);
        check("rst_rblk",  rq_rblk, '0);
        #12;
        rst_n = 1'b1;
        tick();

        // Single I-side fill, ack 3 cycles after mem_rd_en
        rq_valid = 2'b01; rq_we = 2'b00; rq_addr0 = 32'h0000_1040;
        tick();
        check("t1_rd_en", BLK'(mem_rd_en), BLK'(1'b1));
        check("t1_wr_en", BLK'(mem_wr_en), BLK'(1'b0));
        check("t1_addr",  BLK'(mem_addr),  BLK'(32'h0000_1040));
        tick();
        check("t1_wr_en_b", BLK'(mem_wr_en), BLK'(1'b0));
        check("t1_done_b",  BLK'(rq_done),   BLK'(2'b00));
        tick();
        mem_ack = 1'b1; mem_rd_blk = pat_a;
        tick();
        mem_ack = 1'b0; rq_valid = 2'b00;
        check("t1_done", BLK'(rq_done), BLK'(2'b01));
        check("t1_err",  BLK'(rq_err),  BLK'(2'b00));
        check("t1_rblk", rq_rblk, pat_a);
        check("t1_rd_en_off", BLK'(mem_rd_en), BLK'(1'b0));
        tick();
        check("t1_done_one_cycle", BLK'(rq_done), BLK'(2'b00));

        // Simultaneous requests right after reset: I-side first, then D-side write
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        rq_valid = 2'b11; rq_we = 2'b10;
        rq_addr0 = 32'h0000_3000; rq_addr1 = 32'h0000_2000; rq_wblk1 = pat_b;
        tick();
        check("t2_first_addr",  BLK'(mem_addr),  BLK'(32'h0000_3000));
        check("t2_first_rd_en", BLK'(mem_rd_en), BLK'(1'b1));
        mem_ack = 1'b1; mem_rd_blk = pat_c;
        tick();
        mem_ack = 1'b0; rq_valid = 2'b10;
        check("t2_first_done", BLK'(rq_done), BLK'(2'b01));
        check("t2_first_rblk", rq_rblk, pat_c);
        tick();
        tick();
        check("t2_second_wr_en", BLK'(mem_wr_en), BLK'(1'b1));
        check("t2_second_rd_en", BLK'(mem_rd_en), BLK'(1'b0));
        check("t2_second_addr",  BLK'(mem_addr),  BLK'(32'h0000_2000));
        check("t2_second_wblk",  mem_wr_blk, pat_b);
        mem_ack = 1'b1; mem_rd_blk = pat_d;
        tick();
        mem_ack = 1'b0; rq_valid = 2'b00;
        check("t2_second_done", BLK'(rq_done), BLK'(2'b10));
        check("t2_write_keeps_rblk", rq_rblk, pat_c);
        tick();

        // Sustained contention, ack latency 1: owners alternate 0,1,0,1,0,1
        rq_valid = 2'b11; rq_we = 2'b00;
        rq_addr0 = 32'h0000_0100; rq_addr1 = 32'h0000_0200;
        mem_rd_blk = pat_e;
        last_done_cyc = 0;
        for (int i = 0; i < 6; i++) begin
            exp_addr = (i % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200;
            exp_done = (i % 2 == 0) ? 2'b01 : 2'b10;
            tick();
            check($sformatf("t3_grant_addr_%0d", i), BLK'(mem_addr), BLK'(exp_addr));
            mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
            check($sformatf("t3_done_%0d", i), BLK'(rq_done), BLK'(exp_done));
            if (i > 0) begin
                gap = cyc - last_done_cyc;
                check($sformatf("t3_gap_%0d", i), BLK'(gap >= 3), BLK'(1'b1));
            end
            last_done_cyc = cyc;
            tick();
        end
        rq_valid = 2'b00;
        tick();

        // Timeout: D-side write never acknowledged
        rq_valid = 2'b10; rq_we = 2'b10; rq_addr1 = 32'h0000_7000;
        tick();
        check("t4_wr_en", BLK'(mem_wr_en), BLK'(1'b1));
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("t4_busy_%0d", k), BLK'({mem_wr_en, rq_done}), BLK'(3'b100));
        end
        tick();
        rq_valid = 2'b00;
        check("t4_done",  BLK'(rq_done),   BLK'(2'b10));
        check("t4_err",   BLK'(rq_err),    BLK'(2'b10));
        check("t4_wr_en_off", BLK'(mem_wr_en), BLK'(1'b0));
        check("t4_rblk_kept", rq_rblk, pat_e);
        tick();
        check("t4_err_one_cycle", BLK'(rq_err), BLK'(2'b00));
        rq_valid = 2'b01; rq_we = 2'b00; rq_addr0 = 32'h0000_4000;
        tick();
        check("t4_next_addr",  BLK'(mem_addr),  BLK'(32'h0000_4000));
        check("t4_next_rd_en", BLK'(mem_rd_en), BLK'(1'b1));
        mem_ack = 1'b1; mem_rd_blk = pat_a;
        tick();
        mem_ack = 1'b0; rq_valid = 2'b00;
        check("t4_next_done", BLK'(rq_done), BLK'(2'b01));
        check("t4_next_err",  BLK'(rq_err),  BLK'(2'b00));
        tick();

        // Reset mid-transaction
        rq_valid = 2'b01; rq_addr0 = 32'h0000_5500;
        tick();
        check("t5_busy_rd_en", BLK'(mem_rd_en), BLK'(1'b1));
        #2;
        rst_n = 1'b0;
        rq_valid = 2'b10; rq_we = 2'b10; rq_addr1 = 32'h0000_6600; rq_wblk1 = pat_d;
        #1;
        check_idle_outputs("t5_in_reset");
        check("t5_addr_cleared", BLK'(mem_addr), BLK'(32'h0));
        check("t5_rblk_cleared", rq_rblk, '0);
        tick();
        check("t5_no_done", BLK'(rq_done), BLK'(2'b00));
        #3;
        rst_n = 1'b1;
        tick();
        check("t5_regrant_wr_en", BLK'(mem_wr_en), BLK'(1'b1));
        check("t5_regrant_addr",  BLK'(mem_addr),  BLK'(32'h0000_6600));
        check("t5_regrant_nodone", BLK'(rq_done),  BLK'(2'b00));
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0; rq_valid = 2'b00;
        check("t5_done", BLK'(rq_done), BLK'(2'b10));
        tick();

        // Stray ack in IDLE, then input churn during BUSY
        mem_ack = 1'b1; mem_rd_blk = pat_b;
        tick();
        check_idle_outputs("t6_stray1");
        tick();
        check_idle_outputs("t6_stray2");
        mem_ack = 1'b0;
        rq_valid = 2'b01; rq_we = 2'b00; rq_addr0 = 32'h0000_5000;
        tick();
        check("t6_addr", BLK'(mem_addr), BLK'(32'h0000_5000));
        rq_addr0 = 32'h0000_6000; rq_valid = 2'b00; rq_we = 2'b01;
        tick();
        check("t6_addr_held",  BLK'(mem_addr),  BLK'(32'h0000_5000));
        check("t6_rd_en_held", BLK'(mem_rd_en), BLK'(1'b1));
        check("t6_wr_en_held", BLK'(mem_wr_en), BLK'(1'b0));
        mem_ack = 1'b1; mem_rd_blk = pat_c;
        tick();
        mem_ack = 1'b0;
        check("t6_done", BLK'(rq_done), BLK'(2'b01));
        check("t6_rblk", rq_rblk, pat_c);
        tick();
        check("t6_done_cleared", BLK'(rq_done), BLK'(2'b00));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
